// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch front-end; optional static predecode under FETCH_BTFN_PREDICT_EN
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h1eceb000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    output logic [3:0]  imem_rmask,
    input  logic [31:0] imem_rdata,
    input  logic        imem_resp,
    output logic [31:0] iq_pc,
    output logic [31:0] iq_inst,
    output logic [31:0] iq_pc_next,
    output logic        iq_enqueue,
    input  logic        iq_full,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_HOLD    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] hold_inst_q, hold_inst_d;
    logic [31:0] hold_npc_q, hold_npc_d;
    logic [31:0] fetch_npc;

`ifdef FETCH_BTFN_PREDICT_EN
    logic [31:0] imm_j;
    logic [31:0] imm_b;
    logic        is_jal;
    logic        is_back_branch;

    assign imm_j          = {{12{imem_rdata[31]}}, imem_rdata[19:12], imem_rdata[20],
                             imem_rdata[30:21], 1'b0};
    assign imm_b          = {{20{imem_rdata[31]}}, imem_rdata[7], imem_rdata[30:25],
                             imem_rdata[11:8], 1'b0};
    assign is_jal         = (imem_rdata[6:0] == 7'b1101111);
    // Backward-taken / forward-not-taken: only negative branch offsets are followed.
    assign is_back_branch = (imem_rdata[6:0] == 7'b1100011) && imem_rdata[31];

    always_comb begin
        fetch_npc = pc_q + 32'd4;
        if (is_jal) begin
            fetch_npc = pc_q + imm_j;
        end else if (is_back_branch) begin
            fetch_npc = pc_q + imm_b;
        end
    end
`else
    assign fetch_npc = pc_q + 32'd4;
`endif

    assign imem_addr = pc_q;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        hold_inst_d = hold_inst_q;
        hold_npc_d  = hold_npc_q;
        imem_rmask  = 4'h0;
        iq_enqueue  = 1'b0;
        iq_pc       = 32'h0;
        iq_inst     = 32'h0;
        iq_pc_next  = 32'h0;

        case (state_q)
            S_FETCH: begin
                imem_rmask = 4'hf;
                if (redirect) begin
                    pc_d    = redirect_pc;
                    state_d = imem_resp ? S_FETCH : S_DISCARD;
                end else if (imem_resp) begin
                    if (!iq_full) begin
                        iq_enqueue = 1'b1;
                        iq_pc      = pc_q;
                        iq_inst    = imem_rdata;
                        iq_pc_next = fetch_npc;
                        pc_d       = fetch_npc;
                    end else begin
                        hold_inst_d = imem_rdata;
                        hold_npc_d  = fetch_npc;
                        state_d     = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                // pc_q still addresses the buffered instruction while holding.
                if (redirect) begin
                    pc_d    = redirect_pc;
                    state_d = S_FETCH;
                end else if (!iq_full) begin
                    iq_enqueue = 1'b1;
                    iq_pc      = pc_q;
                    iq_inst    = hold_inst_q;
                    iq_pc_next = hold_npc_q;
                    pc_d       = hold_npc_q;
                    state_d    = S_FETCH;
                end
            end
            S_DISCARD: begin
                if (redirect) begin
                    pc_d = redirect_pc;
                end
                if (imem_resp) begin
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        if (rst) begin
            imem_rmask = 4'h0;
            iq_enqueue = 1'b0;
            iq_pc      = 32'h0;
            iq_inst    = 32'h0;
            iq_pc_next = 32'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            hold_inst_q <= 32'h0;
            hold_npc_q  <= 32'h0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            hold_inst_q <= hold_inst_d;
            hold_npc_q  <= hold_npc_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h1eceb000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic [31:0] iq_pc;
    logic [31:0] iq_inst;
    logic [31:0] iq_pc_next;
    logic        iq_enqueue;
    logic        iq_full;
    logic        redirect;
    logic [31:0] redirect_pc;

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_addr   (imem_addr),
        .imem_rmask  (imem_rmask),
        .imem_rdata  (imem_rdata),
        .imem_resp   (imem_resp),
        .iq_pc       (iq_pc),
        .iq_inst     (iq_inst),
        .iq_pc_next  (iq_pc_next),
        .iq_enqueue  (iq_enqueue),
        .iq_full     (iq_full),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Memory responder and reference model state
    bit          rsp_pend;
    int          rsp_cnt;
    logic [31:0] rsp_addr;
    bit          rsp_stale;
    int          lat_min = 1;
    int          lat_max = 1;
    logic [31:0] exp_pc;
    bit          owed;
    bit          rand_mem;
    logic [31:0] mem [logic [31:0]];

    bit          obs_enq;
    bit          obs_resp;
    logic [31:0] obs_pc, obs_inst, obs_npc, obs_addr;
    logic [3:0]  obs_rmask;
    logic [31:0] enq_pcs[$];
    logic [31:0] enq_npcs[$];
    logic [31:0] req_addrs[$];

    function automatic logic [31:0] enc_jal(input int imm);
        logic [20:0] i;
        i = imm[20:0];
        return {i[20], i[10:1], i[11], i[19:12], 5'd1, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_br(input int imm);
        logic [12:0] i;
        i = imm[12:0];
        return {i[12], i[10:5], 5'd2, 5'd1, 3'b000, i[4:1], i[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] gen_word(input logic [31:0] a);
        logic [31:0] h;
        int          off;
        h   = a * 32'h9e3779b1;
        h   = h ^ (h >> 15);
        off = (int'(h[7:3]) + 1) * 4;
        case (h[31:29])
            3'd0:    return enc_jal(h[8] ? -off : off);
            3'd1:    return enc_br(-off);
            3'd2:    return enc_br(off);
            3'd3:    return 32'h00008067;
            default: return 32'h00000013 | {20'h0, h[14:10], 7'h0};
        endcase
    endfunction

    function automatic logic [31:0] memw(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        if (rand_mem) return gen_word(a);
        return 32'h00000013;
    endfunction

    // Predicted successor computed from the instruction's immediate as a signed integer.
    function automatic logic [31:0] ref_npc(input logic [31:0] pc, input logic [31:0] inst);
        int imm;
        imm = 4;
`ifdef FETCH_BTFN_PREDICT_EN
        if ((inst & 32'h7f) == 32'h6f) begin
            imm = ((inst >> 31) != 0 ? -1048576 : 0) + int'((inst >> 12) & 32'hff) * 4096
                + int'((inst >> 20) & 32'h1) * 2048 + int'((inst >> 21) & 32'h3ff) * 2;
        end else if ((inst & 32'h7f) == 32'h63 && (inst >> 31) != 0) begin
            imm = -4096 + int'((inst >> 7) & 32'h1) * 2048
                + int'((inst >> 25) & 32'h3f) * 32 + int'((inst >> 8) & 32'hf) * 2;
        end
`endif
        return pc + 32'(imm);
    endfunction

    task automatic apply_reset(input int n);
        @(negedge clk);
        rst       = 1'b1;
        imem_resp = 1'b0;
        iq_full   = 1'b0;
        redirect  = 1'b0;
        repeat (n) @(posedge clk);
        rsp_pend  = 1'b0;
        rsp_stale = 1'b0;
        owed      = 1'b0;
        exp_pc    = RESET_PC;
        enq_pcs.delete();
        enq_npcs.delete();
        req_addrs.delete();
    endtask

    // One clock: drive responder and inputs, then score the DUT against the model.
    task automatic step(input bit full, input bit redir, input logic [31:0] rpc);
        bit          resp_now;
        logic [31:0] want_inst;
        @(negedge clk);
        rst         = 1'b0;
        resp_now    = rsp_pend && (rsp_cnt == 0);
        imem_resp   = resp_now;
        imem_rdata  = resp_now ? memw(rsp_addr) : $urandom;
        iq_full     = full;
        redirect    = redir;
        redirect_pc = redir ? rpc : {$urandom, 2'b00} >> 2 << 2;
        #1;
        obs_enq   = iq_enqueue;
        obs_resp  = resp_now;
        obs_pc    = iq_pc;
        obs_inst  = iq_inst;
        obs_npc   = iq_pc_next;
        obs_addr  = imem_addr;
        obs_rmask = imem_rmask;

        if (obs_enq && (full || redir)) begin
            vectors++; miscompares++;
            $display("FAIL enq_blocked got enq=1 full=%0d redirect=%0d exp enq=0", full, redir);
        end
        if (obs_enq) begin
            want_inst = memw(exp_pc);
            vectors++;
            if (!((resp_now && !rsp_stale) || owed)) begin
                miscompares++;
                $display("FAIL spurious_enq got pc=%h exp no enqueue", obs_pc);
            end
            vectors++;
            if (obs_pc !== exp_pc || obs_inst !== want_inst || obs_npc !== ref_npc(exp_pc, want_inst)) begin
                miscompares++;
                $display("FAIL enq_data got %h/%h/%h exp %h/%h/%h", obs_pc, obs_inst, obs_npc,
                         exp_pc, want_inst, ref_npc(exp_pc, want_inst));
            end
            enq_pcs.push_back(obs_pc);
            enq_npcs.push_back(obs_npc);
        end
        if (resp_now && !rsp_stale && !redir && !full) begin
            vectors++;
            if (obs_enq !== 1'b1) begin
                miscompares++;
                $display("FAIL enq_on_resp got enq=%0d exp 1", obs_enq);
            end
        end
        if (owed) begin
            vectors++;
            if (obs_rmask !== 4'h0 || (!full && !redir && obs_enq !== 1'b1)) begin
                miscompares++;
                $display("FAIL hold got rmask=%h enq=%0d exp rmask=0 enq=%0d", obs_rmask, obs_enq,
                         !full && !redir);
            end
        end
        if (rsp_pend && obs_rmask == 4'hf) begin
            vectors++;
            if (obs_addr !== rsp_addr) begin
                miscompares++;
                $display("FAIL addr_stable got %h exp %h", obs_addr, rsp_addr);
            end
        end
        if (!rsp_pend && obs_rmask == 4'hf) begin
            vectors++;
            if (obs_addr !== exp_pc || owed) begin
                miscompares++;
                $display("FAIL req_addr got %h owed=%0d exp %h owed=0", obs_addr, owed, exp_pc);
            end
        end

        if (redir) begin
            exp_pc = rpc;
            owed   = 1'b0;
        end else if (obs_enq) begin
            exp_pc = ref_npc(exp_pc, memw(exp_pc));
            owed   = 1'b0;
        end else if (resp_now && !rsp_stale) begin
            owed = 1'b1;
        end

        if (resp_now) begin
            rsp_pend = 1'b0;
        end else if (rsp_pend) begin
            rsp_cnt--;
        end else if (obs_rmask == 4'hf) begin
            rsp_pend  = 1'b1;
            rsp_cnt   = $urandom_range(lat_max, lat_min) - 1;
            rsp_addr  = obs_addr;
            rsp_stale = 1'b0;
            req_addrs.push_back(obs_addr);
        end
        if (redir && rsp_pend) rsp_stale = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst       = 1'b1;
        imem_resp = 1'b1;
        iq_full   = 1'b0;
        redirect  = 1'b0;
        repeat (2) begin
            #1;
            vectors++;
            if (imem_rmask !== 4'h0 || iq_enqueue !== 1'b0 || iq_pc !== 32'h0 ||
                iq_inst !== 32'h0 || iq_pc_next !== 32'h0) begin
                miscompares++;
                $display("FAIL reset_outputs got rmask=%h enq=%0d data=%h/%h/%h exp all 0",
                         imem_rmask, iq_enqueue, iq_pc, iq_inst, iq_pc_next);
            end
            @(negedge clk);
        end
        apply_reset(1);
        step(0, 0, 0);
        vectors++;
        if (obs_addr !== RESET_PC || obs_rmask !== 4'hf) begin
            miscompares++;
            $display("FAIL reset_first_req got %h/%h exp %h/f", obs_addr, obs_rmask, RESET_PC);
        end
    endtask

    task automatic test_sequential();
        mem.delete();
        lat_min = 1; lat_max = 1;
        apply_reset(1);
        for (int i = 0; i < 30 && enq_pcs.size() < 3; i++) step(0, 0, 0);
        vectors++;
        if (enq_pcs.size() < 3) begin
            miscompares++;
            $display("FAIL seq_count got %0d exp 3", enq_pcs.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                vectors++;
                if (enq_pcs[i] !== RESET_PC + 32'(4 * i) || enq_npcs[i] !== RESET_PC + 32'(4 * i + 4) ||
                    req_addrs[i] !== RESET_PC + 32'(4 * i)) begin
                    miscompares++;
                    $display("FAIL seq_%0d got pc=%h npc=%h req=%h exp %h", i, enq_pcs[i], enq_npcs[i],
                             req_addrs[i], RESET_PC + 32'(4 * i));
                end
            end
        end
    endtask

    task automatic test_full_stall();
        bit hit = 0;
        mem.delete();
        lat_min = 1; lat_max = 1;
        apply_reset(1);
        for (int i = 0; i < 20 && !hit; i++) begin
            hit = rsp_pend && rsp_cnt == 0 && rsp_addr == RESET_PC + 32'h4;
            step(hit, 0, 0);
        end
        vectors++;
        if (!hit || obs_enq !== 1'b0) begin
            miscompares++;
            $display("FAIL full_at_resp got hit=%0d enq=%0d exp 1/0", hit, obs_enq);
        end
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0);
            vectors++;
            if (obs_rmask !== 4'h0 || obs_enq !== 1'b0) begin
                miscompares++;
                $display("FAIL full_hold got rmask=%h enq=%0d exp 0/0", obs_rmask, obs_enq);
            end
        end
        step(0, 0, 0);
        vectors++;
        if (obs_enq !== 1'b1 || obs_pc !== RESET_PC + 32'h4) begin
            miscompares++;
            $display("FAIL full_release got enq=%0d pc=%h exp 1/%h", obs_enq, obs_pc, RESET_PC + 32'h4);
        end
        step(0, 0, 0);
        vectors++;
        if (obs_addr !== RESET_PC + 32'h8 || obs_rmask !== 4'hf) begin
            miscompares++;
            $display("FAIL full_next_req got %h/%h exp %h/f", obs_addr, obs_rmask, RESET_PC + 32'h8);
        end
    endtask

    task automatic test_redirect_outstanding();
        int n0;
        mem.delete();
        lat_min = 3; lat_max = 3;
        apply_reset(1);
        step(0, 0, 0);
        n0 = req_addrs.size();
        step(0, 1, 32'h1eceb100);
        for (int i = 0; i < 30 && enq_pcs.size() == 0; i++) step(0, 0, 0);
        vectors++;
        if (enq_pcs.size() == 0 || enq_pcs[0] !== 32'h1eceb100 || req_addrs.size() <= n0 ||
            req_addrs[n0] !== 32'h1eceb100) begin
            miscompares++;
            $display("FAIL redir_outstanding got enqs=%0d reqs=%0d exp first pc/addr 1eceb100",
                     enq_pcs.size(), req_addrs.size());
        end
    endtask

    task automatic test_redirect_coincident();
        mem.delete();
        lat_min = 2; lat_max = 2;
        apply_reset(1);
        for (int i = 0; i < 10 && !(rsp_pend && rsp_cnt == 0); i++) step(0, 0, 0);
        step(0, 1, 32'h1eceb200);
        vectors++;
        if (obs_resp !== 1'b1 || obs_enq !== 1'b0) begin
            miscompares++;
            $display("FAIL redir_coinc got resp=%0d enq=%0d exp 1/0", obs_resp, obs_enq);
        end
        step(0, 0, 0);
        vectors++;
        if (obs_addr !== 32'h1eceb200 || obs_rmask !== 4'hf) begin
            miscompares++;
            $display("FAIL redir_coinc_addr got %h/%h exp 1eceb200/f", obs_addr, obs_rmask);
        end
    endtask

    task automatic test_redirect_hold();
        mem.delete();
        lat_min = 1; lat_max = 1;
        apply_reset(1);
        for (int i = 0; i < 10 && !(rsp_pend && rsp_cnt == 0); i++) step(0, 0, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        step(0, 1, 32'h1eceb300);
        vectors++;
        if (obs_enq !== 1'b0) begin
            miscompares++;
            $display("FAIL redir_hold_enq got %0d exp 0", obs_enq);
        end
        for (int i = 0; i < 20 && enq_pcs.size() < 2; i++) step(0, 0, 0);
        vectors++;
        if (enq_pcs.size() < 2 || enq_pcs[0] !== 32'h1eceb300 || enq_pcs[1] !== 32'h1eceb304) begin
            miscompares++;
            $display("FAIL redir_hold_restart got n=%0d exp 1eceb300,1eceb304", enq_pcs.size());
        end
    endtask

    task automatic test_predict();
        logic [31:0] want;
        bit          hit = 0;
`ifdef FETCH_BTFN_PREDICT_EN
        want = 32'h1eceb00c;
`else
        want = 32'h1eceb014;
`endif
        mem.delete();
        mem[32'h1eceb010] = 32'hfe000ee3;
        lat_min = 1; lat_max = 1;
        apply_reset(1);
        for (int i = 0; i < 40 && !hit; i++) begin
            step(0, 0, 0);
            hit = obs_enq && obs_pc == 32'h1eceb010;
        end
        vectors++;
        if (!hit || obs_npc !== want) begin
            miscompares++;
            $display("FAIL predict_npc got hit=%0d npc=%h exp %h", hit, obs_npc, want);
        end
        step(0, 0, 0);
        vectors++;
        if (obs_addr !== want) begin
            miscompares++;
            $display("FAIL predict_addr got %h exp %h", obs_addr, want);
        end
        mem.delete();
    endtask

    task automatic test_reset_mid();
        lat_min = 3; lat_max = 3;
        apply_reset(1);
        step(0, 0, 0);
        step(0, 0, 0);
        apply_reset(1);
        step(0, 0, 0);
        vectors++;
        if (obs_addr !== RESET_PC || obs_rmask !== 4'hf || obs_enq !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid got %h/%h enq=%0d exp %h/f/0", obs_addr, obs_rmask, obs_enq, RESET_PC);
        end
    endtask

    task automatic test_random();
        int total = 0;
        mem.delete();
        rand_mem = 1'b1;
        lat_min = 1; lat_max = 4;
        apply_reset(1);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) apply_reset($urandom_range(1, 2));
            step($urandom_range(0, 3) == 0, $urandom_range(0, 24) == 0,
                 RESET_PC + ($urandom_range(0, 255) << 2));
            total += int'(obs_enq);
        end
        vectors++;
        if (total < 200) begin
            miscompares++;
            $display("FAIL random_progress got %0d enqueues exp >= 200", total);
        end
        rand_mem = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        imem_resp   = 1'b0;
        imem_rdata  = 32'h0;
        iq_full     = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        rand_mem    = 1'b0;
        test_reset();
        test_sequential();
        test_full_stall();
        test_redirect_outstanding();
        test_redirect_coincident();
        test_redirect_hold();
        test_predict();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "timeout");
    end

endmodule
